// File: rtl/buf_sched_pkg.sv
// Shared definitions for the packet buffer scheduler: FSM encoding, RAM mux
// selection and size defaults.
package buf_sched_pkg;

  localparam int unsigned RAM_WIDTH_DEF     = 8;
  localparam int unsigned RAM_ADDR_BITS_DEF = 11;
  localparam int unsigned CK_TIMEOUT_DEF    = 5000;
  // Two bytes are reserved after the payload for the checksum.
  localparam int unsigned MAX_LEN_DEF       = (1 << RAM_ADDR_BITS_DEF) - 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LENCHK   = 3'd1,
    ST_CK_START = 3'd2,
    ST_CK_RUN   = 3'd3,
    ST_CK_DRAIN = 3'd4,
    ST_TX       = 3'd5
  } state_t;

  function automatic logic [31:0] max_len(input int unsigned addr_bits);
    return (32'd1 << addr_bits) - 32'd2;
  endfunction

endpackage

// File: rtl/buf_sched_mux.sv
// Three-way selection of the shared single-port RAM between receive, the
// checksum engine and transmit, decoded from the registered FSM state.
module buf_sched_mux
  import buf_sched_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int unsigned RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input  state_t                   i_state,
  input  logic                     i_rx_we,
  input  logic [RAM_ADDR_BITS-1:0] i_rx_addr,
  input  logic [RAM_WIDTH-1:0]     i_rx_data,
  input  logic                     i_scs_we,
  input  logic [RAM_ADDR_BITS-1:0] i_scs_addr,
  input  logic [RAM_WIDTH-1:0]     i_scs_data,
  input  logic [RAM_ADDR_BITS-1:0] i_tx_addr,
  output logic                     o_ram_we,
  output logic [RAM_ADDR_BITS-1:0] o_ram_addr,
  output logic [RAM_WIDTH-1:0]     o_ram_din
);

  always_comb begin
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    case (i_state)
      ST_IDLE: begin
        o_ram_we   = i_rx_we;
        o_ram_addr = i_rx_addr;
        o_ram_din  = i_rx_data;
      end
      // Drain keeps the engine's port so its last write still lands.
      ST_CK_RUN, ST_CK_DRAIN: begin
        o_ram_we   = i_scs_we;
        o_ram_addr = i_scs_addr;
        o_ram_din  = i_scs_data;
      end
      ST_TX: begin
        o_ram_addr = i_tx_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/buf_sched.sv
// Single-buffer packet scheduler: receive -> length check -> checksum pass ->
// transmit, with sticky error flags and a released-packet counter.
module buf_sched
  import buf_sched_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int unsigned RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int unsigned CK_TIMEOUT    = CK_TIMEOUT_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     rx_ready,
  input  logic                     rx_we,
  input  logic [RAM_ADDR_BITS-1:0] rx_addr,
  input  logic [RAM_WIDTH-1:0]     rx_data,
  input  logic                     rx_done,
  input  logic [15:0]              rx_len,
  output logic                     scs_reset,
  output logic                     scs_mem_ready,
  output logic [15:0]              scs_payload_len,
  input  logic                     scs_work_complete,
  input  logic                     scs_we,
  input  logic [RAM_ADDR_BITS-1:0] scs_addr,
  input  logic [RAM_WIDTH-1:0]     scs_data,
  output logic                     tx_valid,
  output logic [15:0]              tx_len,
  input  logic [RAM_ADDR_BITS-1:0] tx_addr,
  input  logic                     tx_done,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_din,
  output logic                     err_len,
  output logic                     err_timeout,
  output logic                     err_overrun,
  output logic [15:0]              pkt_count,
  output logic [2:0]               dbg_state
);

  localparam int unsigned     CNT_W    = $clog2(CK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CK_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_len;
  logic             r_err_timeout;
  logic             r_err_overrun;
  logic [15:0]      r_pkt_count;
  logic             w_len_bad;
  logic             w_timeout;

  assign w_len_bad = {16'd0, r_len} > max_len(RAM_ADDR_BITS);
  // Completion in the same cycle as the last allowed count takes priority.
  assign w_timeout = (r_state == ST_CK_RUN) && !scs_work_complete && (r_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (rx_done) w_next_state = ST_LENCHK;
      ST_LENCHK:   w_next_state = w_len_bad ? ST_IDLE : ST_CK_START;
      ST_CK_START: w_next_state = ST_CK_RUN;
      ST_CK_RUN: begin
        if (scs_work_complete) w_next_state = ST_CK_DRAIN;
        else if (w_timeout)    w_next_state = ST_IDLE;
      end
      ST_CK_DRAIN: w_next_state = ST_TX;
      ST_TX:       if (tx_done) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_ready      = 1'b0;
    scs_reset     = 1'b1;
    scs_mem_ready = 1'b0;
    tx_valid      = 1'b0;
    case (r_state)
      ST_IDLE:     rx_ready = 1'b1;
      ST_CK_START, ST_CK_RUN: begin
        scs_reset     = 1'b0;
        scs_mem_ready = 1'b1;
      end
      ST_TX:       tx_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_len         <= '0;
      r_cnt         <= '0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
      r_pkt_count   <= '0;
    end else begin
      if (r_state == ST_IDLE && rx_done) r_len <= rx_len;
      if (r_state == ST_CK_START)    r_cnt <= '0;
      else if (r_state == ST_CK_RUN) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != ST_IDLE && rx_done)    r_err_overrun <= 1'b1;
      if (r_state == ST_LENCHK && w_len_bad) r_err_len    <= 1'b1;
      if (w_timeout)                         r_err_timeout <= 1'b1;
      if (r_state == ST_TX && tx_done)       r_pkt_count  <= r_pkt_count + 16'd1;
    end
  end

  assign scs_payload_len = r_len;
  assign tx_len          = r_len + 16'd2;
  assign err_len         = r_err_len;
  assign err_timeout     = r_err_timeout;
  assign err_overrun     = r_err_overrun;
  assign pkt_count       = r_pkt_count;
  assign dbg_state       = r_state;

  buf_sched_mux #(
    .RAM_WIDTH    (RAM_WIDTH),
    .RAM_ADDR_BITS(RAM_ADDR_BITS)
  ) u_mux (
    .i_state   (r_state),
    .i_rx_we   (rx_we),
    .i_rx_addr (rx_addr),
    .i_rx_data (rx_data),
    .i_scs_we  (scs_we),
    .i_scs_addr(scs_addr),
    .i_scs_data(scs_data),
    .i_tx_addr (tx_addr),
    .o_ram_we  (ram_we),
    .o_ram_addr(ram_addr),
    .o_ram_din (ram_din)
  );

endmodule

// File: doc/buf_sched.md
BUF_SCHED -- requirements
Module: buf_sched

Interface
REQ-001 The module SHALL have parameter RAM_WIDTH, default 8, RAM data width.
REQ-002 The module SHALL have parameter RAM_ADDR_BITS, default 11, RAM address width.
REQ-003 The module SHALL have parameter CK_TIMEOUT, default 5000, the maximum cycles allowed for a checksum pass.
REQ-004 The port clock SHALL be an input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The port reset_n SHALL be an input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The port rx_ready SHALL be an output, 1 bit, high when the buffer is free and accepts receive writes.
REQ-007 The ports rx_we, rx_addr and rx_data SHALL be inputs of 1, RAM_ADDR_BITS and RAM_WIDTH bits, the receive-side RAM write.
REQ-008 The ports rx_done and rx_len SHALL be inputs of 1 and 16 bits: a 1-cycle end-of-packet pulse plus the payload byte count.
REQ-009 The ports scs_reset and scs_mem_ready SHALL be outputs, 1 bit each, driving the checksum engine's reset and start.
REQ-010 The port scs_payload_len SHALL be an output, 16 bits, the latched length.
REQ-011 The port scs_work_complete SHALL be an input, 1 bit, the engine's done flag.
REQ-012 The ports scs_we, scs_addr and scs_data SHALL be inputs of 1, RAM_ADDR_BITS and RAM_WIDTH bits, the engine's RAM port.
REQ-013 The ports tx_valid and tx_len SHALL be outputs of 1 and 16 bits: packet ready, length = latched length + 2.
REQ-014 The ports tx_addr and tx_done SHALL be inputs of RAM_ADDR_BITS and 1 bits: the transmit read address and a 1-cycle release pulse.
REQ-015 The ports ram_we, ram_addr and ram_din SHALL be outputs of 1, RAM_ADDR_BITS and RAM_WIDTH bits, the shared single-port RAM.
REQ-016 The ports err_len, err_timeout and err_overrun SHALL be outputs, 1 bit each, sticky error flags.
REQ-017 The port pkt_count SHALL be an output, 16 bits, the count of packets released to transmit.

Function
REQ-018 The FSM SHALL have states IDLE, LENCHK, CK_START, CK_RUN, CK_DRAIN and TX.
REQ-019 In IDLE, rx_ready SHALL be 1 and the RAM mux SHALL be ram_we=rx_we, ram_addr=rx_addr, ram_din=rx_data.
REQ-020 In all other states, rx_we SHALL be ignored.
REQ-021 On rx_done in IDLE, the block SHALL latch rx_len into scs_payload_len and go to LENCHK.
REQ-022 rx_done outside IDLE SHALL set err_overrun and SHALL be otherwise ignored.
REQ-023 In LENCHK, if len > 2^RAM_ADDR_BITS-2, the block SHALL set err_len and return to IDLE; otherwise it SHALL go to CK_START.
REQ-024 A length of 0 SHALL be legal.
REQ-025 scs_reset SHALL be 1 in every state except CK_START and CK_RUN.
REQ-026 In CK_START (1 cycle), scs_reset SHALL be 0, scs_mem_ready SHALL be 1 and the timeout counter SHALL clear; the next state SHALL be CK_RUN.
REQ-027 In CK_RUN, scs_mem_ready SHALL stay 1 and the RAM mux SHALL select the scs_* port.
REQ-028 On scs_work_complete=1 in CK_RUN, the next state SHALL be CK_DRAIN.
REQ-029 CK_DRAIN SHALL last exactly 1 cycle with the scs_* mux held, so that the engine's final write, presented with work_complete, is committed.
REQ-030 CK_DRAIN SHALL have scs_reset=1 and scs_mem_ready=0; the next state SHALL be TX.
REQ-031 If the timeout counter in CK_RUN reaches CK_TIMEOUT-1 without scs_work_complete, the block SHALL set err_timeout, drive scs_reset=1 and go to IDLE.
REQ-032 If scs_work_complete and the timeout occur in the same cycle, completion SHALL win.
REQ-033 In TX, tx_valid SHALL be 1, ram_we SHALL be 0 and ram_addr SHALL equal tx_addr.
REQ-034 On tx_done in TX, the block SHALL go to IDLE and increment pkt_count, which wraps at 16'hFFFF->0.
REQ-035 tx_done outside TX SHALL be ignored.
REQ-036 In every state other than IDLE, CK_RUN, CK_DRAIN and TX, ram_we SHALL be 0 and ram_addr and ram_din SHALL be 0.
REQ-037 The RAM mux SHALL be combinational from the registered state only.
REQ-038 Error flags SHALL clear only on reset.

Reset
REQ-039 On reset_n=0, the block SHALL asynchronously set state=IDLE, scs_reset=1, scs_mem_ready=0, tx_valid=0, scs_payload_len=0, timeout counter=0, all error flags=0 and pkt_count=0.
REQ-040 Reset asserted mid-checksum or mid-TX SHALL abandon the packet, with no RAM write on the cycle following release.

Structure
REQ-041 A shared package SHALL hold the state encoding (3 bits), the RAM_WIDTH and RAM_ADDR_BITS defaults and the max-length constant 2^RAM_ADDR_BITS-2.
REQ-042 One sub-module, buf_sched_mux, SHALL hold the combinational three-way RAM port selection.
REQ-043 The FSM, counters and flags SHALL remain in buf_sched.

Verification
REQ-044 The bench SHALL write bytes 01 02 03 04 at addresses 0-3 and pulse rx_done with len=4; scs_mem_ready SHALL rise 2 cycles later, the engine-model writes SHALL land at addresses 4 and 5, tx_valid SHALL rise with tx_len=6, and pkt_count SHALL read 1 after tx_done.
REQ-045 The bench SHALL pulse rx_done with len=2047 (RAM_ADDR_BITS=11); err_len SHALL be 1, the block SHALL return to IDLE, and scs_reset SHALL never drop.
REQ-046 The bench SHALL hold the engine model idle after start; err_timeout SHALL set exactly CK_TIMEOUT cycles after CK_START, followed by IDLE with scs_reset=1.
REQ-047 The bench SHALL pulse rx_done and rx_we during TX; err_overrun SHALL be 1, the RAM SHALL see no write, and tx_valid SHALL remain 1.
REQ-048 The bench SHALL pull reset_n low during CK_RUN; all outputs SHALL reach reset values within the same cycle without a clock edge, and a subsequent len=0 packet SHALL complete with writes at addresses 0 and 1.
REQ-049 The bench SHALL run 65536 packets; pkt_count SHALL wrap to 0.
